// File: rtl/mc_controller.sv
// Multicycle RV32I sequencing controller: decodes the latched instruction and
// steps a Moore state machine that drives every datapath select and enable.
// Memory accesses use a req/ready handshake; illegal encodings trap until reset.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_control,
  output logic        trap,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;
  logic        w_funct_ok;
  logic        w_retire;

  // ALU operation for R-type / I-ALU; sub only for R-type (op[5]=1) with funct7b5
  function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic f7b5,
                                           input logic op5);
    logic [2:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = (f7b5 & op5) ? ALU_SUB : ALU_ADD;
      3'b010:  r = ALU_SLT;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  assign w_funct_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);

  // Next-state decode; unused encodings fall back to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = w_funct_ok ? S_EXECUTER : S_TRAP;
          OP_I:         w_next = w_funct_ok ? S_EXECUTEI : S_TRAP;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_BEQ:      w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // An instruction retires on the final transition back to FETCH (JAL via ALUWB)
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BEQ) || ((r_state == S_MEMWRITE) && mem_ready);

  // State register and retired-instruction counter, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  // Moore output decode; FETCH/BEQ enables gated by mem_ready/zero
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    trap        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = alu_funct(funct3, funct7b5, op[5]);
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_funct(funct3, funct7b5, op[5]);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Immediate format straight from the opcode
  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected output vectors are
// queued as stimulus is driven and popped when the DUT outputs are sampled.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic [31:0] instret;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_instret = 0;
  logic [21:0] scb[$];
  logic [21:0] e;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
    .trap(trap), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] obs();
    return {state, trap, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, result_src, imm_src, alu_control};
  endfunction

  // Expected outputs for a given state and inputs, from the controller's output table
  function automatic logic [21:0] model(int st, logic rdy, logic z, logic [6:0] o,
                                        logic [2:0] f3, logic f7);
    logic tr, mr, mw, as, irw, pcw, rw;
    logic [1:0] sa, sbv, rs, is;
    logic [2:0] ac, fd;
    tr = 0; mr = 0; mw = 0; as = 0; irw = 0; pcw = 0; rw = 0;
    sa = 0; sbv = 0; rs = 0; ac = 0;
    case (f3)
      3'b000:  fd = (f7 && o[5]) ? 3'b001 : 3'b000;
      3'b010:  fd = 3'b101;
      3'b110:  fd = 3'b011;
      3'b111:  fd = 3'b010;
      default: fd = 3'b000;
    endcase
    case (st)
      0:  begin mr = 1; sbv = 2; rs = 2; irw = rdy; pcw = rdy; end
      1:  begin sa = 1; sbv = 1; end
      2:  begin sa = 2; sbv = 1; end
      3:  begin mr = 1; as = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin mr = 1; mw = 1; as = 1; end
      6:  begin sa = 2; ac = fd; end
      7:  begin rw = 1; end
      8:  begin sa = 2; sbv = 1; ac = fd; end
      9:  begin sa = 1; sbv = 2; pcw = 1; end
      10: begin sa = 2; ac = 3'b001; pcw = z; end
      11: begin tr = 1; end
      default: ;
    endcase
    case (o)
      7'b0100011: is = 2'b01;
      7'b1100011: is = 2'b10;
      7'b1101111: is = 2'b11;
      default:    is = 2'b00;
    endcase
    return {st[3:0], tr, mr, mw, as, irw, pcw, rw, sa, sbv, rs, is, ac};
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic test_reset();
    set_instr(7'b0110011, 3'b000, 1'b0);
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    scb.push_back(model(0, 1'b1, zero, op, funct3, funct7b5));
    e = scb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL reset_outs got=%h exp=%h", obs(), e);
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_fail++; $display("FAIL reset_instret got=%0d exp=0", instret);
    end
    mem_ready = 1'b0;
    #1 reset = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_add();
    int st[4] = '{0, 1, 6, 7};
    set_instr(7'b0110011, 3'b000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      scb.push_back(model(st[c], 1'b1, zero, op, funct3, funct7b5));
      #1;
      e = scb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL add c%0d got=%h exp=%h", c, obs(), e);
      end
    end
    exp_instret++;
    @(posedge clk); #1;
    n_cmp++;
    if (instret !== exp_instret || state !== 4'd0) begin
      n_fail++; $display("FAIL add_retire instret=%0d state=%0d exp=%0d/0", instret, state, exp_instret);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops[5] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
    logic [2:0] f3s[5] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
    logic       f7s[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] acs[5] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010};
    int st[4];
    for (int k = 0; k < 5; k++) begin
      set_instr(ops[k], f3s[k], f7s[k]);
      st = '{0, 1, (ops[k][5] ? 6 : 8), 7};
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        mem_ready = 1'b1;
        scb.push_back(model(st[c], 1'b1, zero, op, funct3, funct7b5));
        #1;
        e = scb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
          n_fail++; $display("FAIL aluop%0d c%0d got=%h exp=%h", k, c, obs(), e);
        end
        if (c == 2) begin
          n_cmp++;
          if (alu_control !== acs[k]) begin
            n_fail++; $display("FAIL aluop%0d_ctl got=%b exp=%b", k, alu_control, acs[k]);
          end
        end
      end
      exp_instret++;
      @(posedge clk); #1;
      n_cmp++;
      if (instret !== exp_instret) begin
        n_fail++; $display("FAIL aluop%0d_instret got=%0d exp=%0d", k, instret, exp_instret);
      end
    end
  endtask

  task automatic test_lw_wait();
    int   st[8]  = '{0, 1, 2, 3, 3, 3, 3, 4};
    logic rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    set_instr(7'b0000011, 3'b010, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      scb.push_back(model(st[c], rdy[c], zero, op, funct3, funct7b5));
      #1;
      e = scb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL lw_wait c%0d got=%h exp=%h", c, obs(), e);
      end
    end
    exp_instret++;
    @(posedge clk); #1;
    n_cmp++;
    if (instret !== exp_instret || state !== 4'd0) begin
      n_fail++; $display("FAIL lw_retire instret=%0d state=%0d exp=%0d/0", instret, state, exp_instret);
    end
  endtask

  task automatic test_sw_jal();
    int st_sw[4]  = '{0, 1, 2, 5};
    int st_jal[4] = '{0, 1, 9, 7};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_instr(7'b0100011, 3'b010, 1'b0);
      else        set_instr(7'b1101111, 3'b000, 1'b0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        mem_ready = 1'b1;
        scb.push_back(model((k == 0) ? st_sw[c] : st_jal[c], 1'b1, zero, op, funct3, funct7b5));
        #1;
        e = scb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
          n_fail++; $display("FAIL %s c%0d got=%h exp=%h", (k == 0) ? "sw" : "jal", c, obs(), e);
        end
      end
      exp_instret++;
      @(posedge clk); #1;
      n_cmp++;
      if (instret !== exp_instret || state !== 4'd0) begin
        n_fail++; $display("FAIL %s_retire instret=%0d state=%0d exp=%0d/0",
                           (k == 0) ? "sw" : "jal", instret, state, exp_instret);
      end
    end
  endtask

  task automatic test_fetch_wait();
    int   st[6]  = '{0, 0, 0, 1, 6, 7};
    logic rdy[6] = '{0, 0, 1, 1, 1, 1};
    set_instr(7'b0110011, 3'b110, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      scb.push_back(model(st[c], rdy[c], zero, op, funct3, funct7b5));
      #1;
      e = scb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL fetch_wait c%0d got=%h exp=%h", c, obs(), e);
      end
    end
    exp_instret++;
    @(posedge clk); #1;
    n_cmp++;
    if (instret !== exp_instret) begin
      n_fail++; $display("FAIL fetch_wait_instret got=%0d exp=%0d", instret, exp_instret);
    end
  endtask

  task automatic test_beq();
    int st[3] = '{0, 1, 10};
    set_instr(7'b1100011, 3'b000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        mem_ready = 1'b1;
        scb.push_back(model(st[c], 1'b1, zero, op, funct3, funct7b5));
        #1;
        e = scb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
          n_fail++; $display("FAIL beq_z%0d c%0d got=%h exp=%h", zero, c, obs(), e);
        end
      end
      exp_instret++;
      @(posedge clk); #1;
      n_cmp++;
      if (instret !== exp_instret || state !== 4'd0) begin
        n_fail++; $display("FAIL beq_z%0d_retire instret=%0d state=%0d exp=%0d/0",
                           zero, instret, state, exp_instret);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_reset_midwrite();
    int   st[4]  = '{0, 1, 2, 5};
    logic rdy[4] = '{1, 1, 1, 0};
    set_instr(7'b0100011, 3'b010, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      scb.push_back(model(st[c], rdy[c], zero, op, funct3, funct7b5));
      #1;
      e = scb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL midwrite c%0d got=%h exp=%h", c, obs(), e);
      end
    end
    #1 reset = 1'b1;
    exp_instret = 0;
    scb.push_back(model(0, 1'b0, zero, op, funct3, funct7b5));
    #1;
    e = scb.pop_front();
    n_cmp++;
    if (obs() !== e || instret !== 32'd0) begin
      n_fail++; $display("FAIL midwrite_reset got=%h/%0d exp=%h/0", obs(), instret, e);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_trap();
    int st[22];
    for (int i = 0; i < 22; i++) st[i] = (i < 2) ? i : 11;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_instr(7'b1110011, 3'b000, 1'b0);
      else        set_instr(7'b0110011, 3'b001, 1'b0);
      for (int c = 0; c < 22; c++) begin
        @(negedge clk);
        mem_ready = 1'b1;
        scb.push_back(model(st[c], 1'b1, zero, op, funct3, funct7b5));
        #1;
        e = scb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
          n_fail++; $display("FAIL trap%0d c%0d got=%h exp=%h", k, c, obs(), e);
        end
      end
      n_cmp++;
      if (instret !== exp_instret) begin
        n_fail++; $display("FAIL trap%0d_instret got=%0d exp=%0d", k, instret, exp_instret);
      end
      #1 reset = 1'b1;
      exp_instret = 0;
      #1;
      n_cmp++;
      if (state !== 4'd0 || trap !== 1'b0 || instret !== 32'd0) begin
        n_fail++; $display("FAIL trap%0d_reset state=%0d trap=%b instret=%0d exp=0/0/0",
                           k, state, trap, instret);
      end
      mem_ready = 1'b0;
      #1 reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_lw_wait();
    test_sw_jal();
    test_fetch_wait();
    test_beq();
    test_reset_midwrite();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
